// File: rtl/carryless_multiplier_unit_pkg.sv
// Shared types for the carry-less multiplier: operation codes, FSM states and
// raw-opcode decode.
package carryless_pkg;

  typedef enum logic [1:0] {
    CLMUL  = 2'b00,
    CLMULH = 2'b01,
    CLMULR = 2'b10
  } clmul_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPUTE = 2'b01,
    DONE    = 2'b10
  } clmul_fsm_t;

  // The reserved encoding 11 runs as a plain CLMUL.
  function automatic clmul_op_t decode_op(input logic [1:0] raw);
    case (raw)
      2'b01:   decode_op = CLMULH;
      2'b10:   decode_op = CLMULR;
      default: decode_op = CLMUL;
    endcase
  endfunction

endpackage

// File: rtl/carryless_multiplier_unit_step.sv
// One shift-and-XOR step: folds a BITS_PER_CYCLE slice of B into the
// double-width GF(2) accumulator.
module carryless_step #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic [2*DATA_WIDTH-1:0]            acc,
  input  logic [DATA_WIDTH-1:0]              a,
  input  logic [BITS_PER_CYCLE-1:0]          b_slice,
  input  logic [$clog2(2*DATA_WIDTH)-1:0]    base_shift,
  output logic [2*DATA_WIDTH-1:0]            acc_next
);

  localparam int unsigned ACC_W   = 2 * DATA_WIDTH;
  localparam int unsigned SHIFT_W = $clog2(ACC_W);

  always_comb begin
    acc_next = acc;
    for (int j = 0; j < int'(BITS_PER_CYCLE); j++) begin
      if (b_slice[j]) begin
        acc_next = acc_next ^ (ACC_W'(a) << (base_shift + SHIFT_W'(j)));
      end
    end
  end

endmodule

// File: rtl/carryless_multiplier_unit.sv
// Multi-cycle carry-less multiplier with valid/ready on both sides; returns the
// low, high or reversed word of the 2*DATA_WIDTH-bit GF(2) product.
module carryless_multiplier_unit
  import carryless_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] operand_A_i,
  input  logic [DATA_WIDTH-1:0] operand_B_i,
  input  logic [1:0]            operation_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int unsigned ACC_W   = 2 * DATA_WIDTH;
  localparam int unsigned N_STEPS = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int unsigned SHIFT_W = $clog2(ACC_W);

  if ((DATA_WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
    $error("BITS_PER_CYCLE must divide DATA_WIDTH");
  end

  clmul_fsm_t             state_q, state_d;
  clmul_op_t              op_q;
  logic [DATA_WIDTH-1:0]  a_q, b_q, result_q;
  logic [ACC_W-1:0]       acc_q, acc_next;
  logic [CNT_W-1:0]       cnt_q;
  logic [SHIFT_W-1:0]     base_shift;
  logic                   last_step;

  assign last_step  = (cnt_q == CNT_W'(N_STEPS - 1));
  assign base_shift = SHIFT_W'(cnt_q) * SHIFT_W'(BITS_PER_CYCLE);

  carryless_step #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc        (acc_q),
    .a          (a_q),
    .b_slice    (b_q[BITS_PER_CYCLE-1:0]),
    .base_shift (base_shift),
    .acc_next   (acc_next)
  );

  // The product's top bit is always zero, so the reversed word is acc[2W-2:W-1].
  function automatic logic [DATA_WIDTH-1:0] select_word(input logic [ACC_W-1:0] acc,
                                                        input clmul_op_t op);
    case (op)
      CLMULH:  return acc[ACC_W-1:DATA_WIDTH];
      CLMULR:  return acc[ACC_W-2:DATA_WIDTH-1];
      default: return acc[DATA_WIDTH-1:0];
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i)   state_d = COMPUTE;
      COMPUTE: if (last_step) state_d = DONE;
      DONE:    if (ready_i)   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == IDLE);
    valid_o = (state_q == DONE);
  end

  assign result_o = result_q;

  // Operand, accumulator, step counter and result registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= CLMUL;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            a_q   <= operand_A_i;
            b_q   <= operand_B_i;
            op_q  <= decode_op(operation_i);
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        COMPUTE: begin
          acc_q <= acc_next;
          b_q   <= b_q >> BITS_PER_CYCLE;
          if (last_step) begin
            cnt_q    <= '0;
            result_q <= select_word(acc_next, op_q);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_carryless_multiplier_unit.sv
// Directed and random checks of carryless_multiplier_unit at BITS_PER_CYCLE
// 1, 4, 8 and 32 against a bitwise GF(2) reference.
module tb_carryless_multiplier_unit;

  localparam int unsigned DW   = 32;
  localparam int          NCFG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          valid_in   [NCFG];
  logic          ready_out  [NCFG];
  logic          valid_out  [NCFG];
  logic          ready_in   [NCFG];
  logic [DW-1:0] a_in       [NCFG];
  logic [DW-1:0] b_in       [NCFG];
  logic [DW-1:0] result_out [NCFG];
  logic [1:0]    op_in      [NCFG];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned BPC = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 32;
    carryless_multiplier_unit #(
      .DATA_WIDTH     (DW),
      .BITS_PER_CYCLE (BPC)
    ) u_dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .valid_i     (valid_in[g]),
      .ready_o     (ready_out[g]),
      .operand_A_i (a_in[g]),
      .operand_B_i (b_in[g]),
      .operation_i (op_in[g]),
      .valid_o     (valid_out[g]),
      .ready_i     (ready_in[g]),
      .result_o    (result_out[g])
    );
  end

  function automatic int bpc_of(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      2:       return 8;
      default: return 32;
    endcase
  endfunction

  function automatic logic [DW-1:0] clmul_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [1:0] op);
    logic [2*DW-1:0] p;
    p = '0;
    for (int i = 0; i < int'(DW); i++) begin
      if (b[i]) p = p ^ ({{DW{1'b0}}, a} << i);
    end
    case (op)
      2'b01:   return p[2*DW-1:DW];
      2'b10:   return p[2*DW-2:DW-1];
      default: return p[DW-1:0];
    endcase
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction on config k; optional DONE stall with new requests pulsed.
  task automatic run_op(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [1:0] op, input logic [DW-1:0] exp,
                        input int stall, input bit pulse, input string tag);
    int cnt;
    bit ready_seen;
    @(negedge clk);
    a_in[k] = a; b_in[k] = b; op_in[k] = op;
    valid_in[k] = 1'b1; ready_in[k] = 1'b0;
    cnt = 0;
    while (ready_out[k] !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, " accept"}, 32'(ready_out[k]), 32'd1);
    @(negedge clk);
    valid_in[k] = 1'b0;
    a_in[k] = ~a; b_in[k] = ~b; op_in[k] = ~op;
    cnt = 0;
    ready_seen = 1'b0;
    while (valid_out[k] !== 1'b1 && cnt < 200) begin
      if (ready_out[k] !== 1'b0) ready_seen = 1'b1;
      @(negedge clk);
      cnt++;
    end
    if (ready_out[k] !== 1'b0) ready_seen = 1'b1;
    check({tag, " latency"}, 32'(cnt), 32'(DW / bpc_of(k)));
    check({tag, " ready_low"}, 32'(ready_seen), 32'd0);
    check({tag, " result"}, result_out[k], exp);
    for (int s = 0; s < stall; s++) begin
      if (pulse) begin
        a_in[k] = $urandom; b_in[k] = $urandom; op_in[k] = 2'(s);
        valid_in[k] = 1'b1;
      end
      @(negedge clk);
      check({tag, " stall_valid"}, 32'(valid_out[k]), 32'd1);
      check({tag, " stall_ready"}, 32'(ready_out[k]), 32'd0);
      check({tag, " stall_result"}, result_out[k], exp);
    end
    valid_in[k] = 1'b0;
    ready_in[k] = 1'b1;
    @(negedge clk);
    ready_in[k] = 1'b0;
    check({tag, " post_ready"}, 32'(ready_out[k]), 32'd1);
    check({tag, " post_valid"}, 32'(valid_out[k]), 32'd0);
    check({tag, " post_result"}, result_out[k], exp);
    if (pulse) begin
      @(negedge clk);
      check({tag, " not_taken"}, 32'(ready_out[k]), 32'd1);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NCFG; k++) begin
      valid_in[k] = 1'b0; ready_in[k] = 1'b0;
      a_in[k] = '0; b_in[k] = '0; op_in[k] = 2'b00;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NCFG; k++) begin
      check("reset ready", 32'(ready_out[k]), 32'd1);
      check("reset valid", 32'(valid_out[k]), 32'd0);
      check("reset result", result_out[k], 32'h0);
    end
    rst_n = 1'b1;

    run_op(1, 32'h3, 32'h3, 2'b00, 32'h0000_0005, 0, 1'b0, "clmul_3x3");
    run_op(1, 32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000, 1, 1'b0, "msb_clmulh");
    run_op(1, 32'h8000_0000, 32'h8000_0000, 2'b10, 32'h8000_0000, 0, 1'b0, "msb_clmulr");
    run_op(1, 32'h8000_0000, 32'h8000_0000, 2'b00, 32'h0000_0000, 2, 1'b0, "msb_clmul");
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h5555_5555, 0, 1'b0, "ones_clmul");
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'h5555_5555, 0, 1'b0, "ones_clmulh");
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hAAAA_AAAA, 0, 1'b0, "ones_clmulr");
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'h5555_5555, 0, 1'b0, "ones_op11");
    run_op(1, 32'h6, 32'h3, 2'b00, 32'h0000_000A, 5, 1'b1, "backpressure");

    // Reset lands on the third COMPUTE edge of an in-flight request.
    @(negedge clk);
    a_in[1] = 32'h7; b_in[1] = 32'h9; op_in[1] = 2'b00; valid_in[1] = 1'b1;
    @(negedge clk);
    valid_in[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset ready", 32'(ready_out[1]), 32'd1);
    check("midreset valid", 32'(valid_out[1]), 32'd0);
    check("midreset result", result_out[1], 32'h0);
    run_op(1, 32'h5, 32'h3, 2'b00, 32'h0000_000F, 0, 1'b0, "after_reset");

    for (int k = 0; k < NCFG; k++) begin
      for (int n = 0; n < 250; n++) begin
        logic [DW-1:0] ra, rb;
        logic [1:0]    rop;
        ra  = $urandom;
        rb  = $urandom;
        rop = 2'($urandom_range(0, 3));
        run_op(k, ra, rb, rop, clmul_ref(ra, rb, rop), int'($urandom_range(0, 3)), 1'b0,
               $sformatf("rand_bpc%0d", bpc_of(k)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/carryless_multiplier_unit.md
Name: carryless_multiplier_unit

Overview:
- Multi-cycle sequencer for carry-less (GF(2) polynomial) multiplication producing a full 2*DATA_WIDTH-bit product.
- Processes BITS_PER_CYCLE bits of operand B per clock using shift-and-XOR into a double-width accumulator.
- Returns low (CLMUL), high (CLMULH) or reversed (CLMULR) word per the RISC-V Zbc definitions.
- Sits behind an execute-stage issue port; valid/ready handshakes on both input and output sides.

Parameters:
- DATA_WIDTH, 32, operand and result width in bits.
- BITS_PER_CYCLE, 4, operand B bits consumed per COMPUTE cycle; must divide DATA_WIDTH; elaboration error otherwise.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_n_i  input  1  synchronous active-low reset.
- valid_i  input  1  request valid.
- ready_o  output  1  unit can accept a request.
- operand_A_i  input  DATA_WIDTH  multiplicand.
- operand_B_i  input  DATA_WIDTH  multiplier.
- operation_i  input  2  00 CLMUL, 01 CLMULH, 10 CLMULR, 11 reserved (executes as CLMUL).
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts result.
- result_o  output  DATA_WIDTH  selected result word.

Behaviour:
- Clock is clk_i. Reset rst_n_i is synchronous and active-low: sampled on the clk_i rising edge.
- Reset, from any state including mid-COMPUTE, forces: state IDLE, accumulator 0, counter 0, result register 0, operation register CLMUL. The in-flight request is discarded.
- Outputs after reset: ready_o=1, valid_o=0, result_o=0.
- FSM states: IDLE, COMPUTE, DONE.
- IDLE:
  - ready_o=1, valid_o=0.
  - On valid_i&&ready_o: latch A, B and operation (11 mapped to CLMUL); clear the accumulator; counter=0; go to COMPUTE.
- COMPUTE:
  - ready_o=0, valid_o=0.
  - Each cycle, for j in 0..BITS_PER_CYCLE-1: if Breg[j], then acc ^= zero-extended A << (counter*BITS_PER_CYCLE + j).
  - Then Breg >>= BITS_PER_CYCLE and counter++.
  - After DATA_WIDTH/BITS_PER_CYCLE cycles (counter reaches last value), load the result register and go to DONE.
  - Fixed latency: no early exit on zero remaining bits.
- Result select, from acc[2*DATA_WIDTH-1:0]:
  - CLMUL = acc[DATA_WIDTH-1:0].
  - CLMULH = acc[2*DATA_WIDTH-1:DATA_WIDTH].
  - CLMULR = acc[2*DATA_WIDTH-2:DATA_WIDTH-1].
  - acc bit 2*DATA_WIDTH-1 is always 0.
- DONE:
  - valid_o=1, ready_o=0.
  - result_o is stable while valid_o=1 and ready_i=0.
  - On ready_i go to IDLE. valid_o drops the next cycle; result_o keeps its last value until the next load.
- Latency: accept at edge E0, valid_o high from edge E(DATA_WIDTH/BITS_PER_CYCLE); 8 cycles at defaults. Throughput is one op per DATA_WIDTH/BITS_PER_CYCLE+2 cycles minimum.
- valid_i while ready_o=0 is ignored, with no side effects; the requester must hold its request.
- Counter width is clog2(DATA_WIDTH/BITS_PER_CYCLE), min 1. Terminal compare is on the count value, no wrap reliance.

Decomposition:
- Package carryless_pkg holds:
  - clmul_op_t enum {CLMUL, CLMULH, CLMULR}.
  - clmul_fsm_t enum {IDLE, COMPUTE, DONE}.
  - Function to decode a raw 2-bit op into clmul_op_t (11 -> CLMUL).
- Sub-module carryless_step: combinational. Inputs: accumulator (2*DATA_WIDTH), A (DATA_WIDTH), a BITS_PER_CYCLE slice of B, base shift. Output: next accumulator.
- The FSM, counter, registers and result select live in the top module.

Test Plan:
- A=0x3, B=0x3, CLMUL → result_o=0x00000005; valid_o exactly 8 cycles after the accept edge; ready_o=0 throughout.
- A=0x80000000, B=0x80000000:
  - CLMULH → 0x40000000.
  - CLMULR → 0x80000000.
  - CLMUL → 0x00000000.
- A=B=0xFFFFFFFF:
  - CLMUL → 0x55555555.
  - CLMULH → 0x55555555.
  - CLMULR → 0xAAAAAAAA.
  - operation 11 → 0x55555555.
- Backpressure: hold ready_i=0 for 5 cycles in DONE and pulse valid_i with new operands → valid_o and result_o stay constant, ready_o=0, new request not taken. After ready_i=1, ready_o=1 next cycle.
- Reset mid-op: assert rst_n_i=0 for one edge at COMPUTE cycle 3 → next cycle ready_o=1, valid_o=0, result_o=0. A following A=0x5, B=0x3 CLMUL → 0x0000000F.
- Random regression: 1000 random A/B/op with random ready_i stalls, compared against a bitwise GF(2) reference model, with BITS_PER_CYCLE swept over 1, 4, 8 and 32.
